// File: rtl/sample_streamer_pkg.sv
// Shared types and constants for the sample_streamer block: mode encoding,
// command bytes and frame marker.
package sample_streamer_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_ECHO   = 2'd1,
    MODE_STREAM = 2'd2
  } mode_e;

  localparam logic [7:0] CMD_IDLE    = 8'hF0;
  localparam logic [7:0] CMD_ECHO    = 8'hF1;
  localparam logic [7:0] CMD_STREAM  = 8'hF2;
  localparam logic [7:0] CMD_CLR_OVF = 8'hF3;
  localparam logic [3:0] CMD_CHAN_HI = 4'hE;

  localparam logic       FRAME_MARK  = 1'b1;
  localparam logic [3:0] CHAN_NONE   = 4'hF;

endpackage

// File: rtl/sample_streamer_if.sv
// Byte/sample/tx port bundle between the AVR-side ports and the streamer.
interface sample_streamer_if #(
  parameter int SAMPLE_W = 10,
  parameter int CHAN_W   = 4
);
  logic [7:0]          rx_data;
  logic                new_rx_data;
  logic                new_sample;
  logic [SAMPLE_W-1:0] sample;
  logic [CHAN_W-1:0]   sample_channel;
  logic                tx_busy;
  logic [7:0]          tx_data;
  logic                new_tx_data;
  logic [CHAN_W-1:0]   channel;
  logic [1:0]          mode;
  logic                overflow;

  modport master (
    output rx_data, new_rx_data, new_sample, sample, sample_channel, tx_busy,
    input  tx_data, new_tx_data, channel, mode, overflow
  );

  modport slave (
    input  rx_data, new_rx_data, new_sample, sample, sample_channel, tx_busy,
    output tx_data, new_tx_data, channel, mode, overflow
  );
endinterface

// File: rtl/sample_streamer_sync_fifo.sv
// Synchronous FIFO with flush and free-entry count; full is judged on the
// registered occupancy, so a push on a full FIFO is refused even with a pop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      free
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full     = (count_r == FULL_CNT);
  assign empty    = (count_r == (AW+1)'(0));
  assign free     = FULL_CNT - count_r;
  assign pop_data = mem_r[rd_ptr_r];
  assign wr_ok_s  = push && !full && !flush;
  assign rd_ok_s  = pop && !empty && !flush;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/sample_streamer.sv
// Mode-switchable serial source: command decoder, echo/stream push logic,
// buffering FIFO and a two-state tx pacer.
module sample_streamer
  import sample_streamer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 10,
  parameter int CHAN_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  sample_streamer_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_GUARD = 1'b1;

  mode_e             mode_r;
  logic [CHAN_W-1:0] channel_r;
  logic              overflow_r;
  logic              pend_r;
  logic [7:0]        pend_byte_r;
  logic [0:0]        state_r;
  logic [7:0]        tx_data_r;
  logic              new_tx_r;

  logic              is_cmd_s, flush_s, clr_ovf_s, echo_data_s, sample_hit_s;
  logic [7:0]        byte0_s, byte1_s;
  logic              push_req_s, push_go_s, pend_set_s, ovf_set_s;
  logic [7:0]        push_byte_s;
  logic              fire_s, bypass_s;
  logic [7:0]        head_s, out_byte_s;
  logic              full_s, empty_s;
  logic [CNT_W-1:0]  free_s;

  assign is_cmd_s     = bus.new_rx_data && (bus.rx_data[7:5] == 3'b111);
  assign flush_s      = bus.new_rx_data && (bus.rx_data == CMD_IDLE);
  assign clr_ovf_s    = bus.new_rx_data && (bus.rx_data == CMD_CLR_OVF);
  assign echo_data_s  = bus.new_rx_data && !is_cmd_s && (mode_r == MODE_ECHO);
  assign sample_hit_s = bus.new_sample && (mode_r == MODE_STREAM) &&
                        (bus.sample_channel == channel_r) && (channel_r != CHAN_NONE);
  assign byte0_s      = {FRAME_MARK, bus.sample_channel, bus.sample[SAMPLE_W-1:SAMPLE_W-3]};
  assign byte1_s      = {1'b0, bus.sample[SAMPLE_W-4:0]};

  // Push source selection; a pending frame byte owns the push slot, so any
  // competing byte or sample in that cycle is dropped as overflow.
  always_comb begin
    push_req_s  = 1'b0;
    push_byte_s = 8'h00;
    pend_set_s  = 1'b0;
    ovf_set_s   = 1'b0;
    if (pend_r) begin
      push_req_s  = 1'b1;
      push_byte_s = pend_byte_r;
      ovf_set_s   = echo_data_s || sample_hit_s;
    end else if (echo_data_s) begin
      push_req_s  = !full_s;
      push_byte_s = bus.rx_data;
      ovf_set_s   = full_s;
    end else if (sample_hit_s) begin
      push_req_s  = (free_s >= CNT_W'(2));
      push_byte_s = byte0_s;
      pend_set_s  = (free_s >= CNT_W'(2));
      ovf_set_s   = (free_s < CNT_W'(2));
    end else begin
      push_req_s  = 1'b0;
    end
  end

  // An empty FIFO is bypassed so a byte can leave in the cycle it arrives.
  assign push_go_s  = push_req_s && !flush_s;
  assign fire_s     = (state_r == ST_READY) && !bus.tx_busy && !flush_s && (!empty_s || push_go_s);
  assign bypass_s   = fire_s && empty_s;
  assign out_byte_s = empty_s ? push_byte_s : head_s;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (push_go_s && !bypass_s),
    .push_data (push_byte_s),
    .pop       (fire_s && !empty_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .free      (free_s)
  );

  // Command decoder registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r     <= MODE_IDLE;
      channel_r  <= CHAN_NONE;
      overflow_r <= 1'b0;
    end else begin
      if (bus.new_rx_data) begin
        case (bus.rx_data)
          CMD_IDLE:   mode_r <= MODE_IDLE;
          CMD_ECHO:   mode_r <= MODE_ECHO;
          CMD_STREAM: mode_r <= MODE_STREAM;
          default:    mode_r <= mode_r;
        endcase
      end
      if (bus.new_rx_data && (bus.rx_data[7:4] == CMD_CHAN_HI)) begin
        channel_r <= bus.rx_data[3:0];
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Second byte of an admitted frame waits here for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r      <= 1'b0;
      pend_byte_r <= 8'h00;
    end else begin
      pend_r <= pend_set_s && !flush_s;
      if (pend_set_s) begin
        pend_byte_r <= byte1_s;
      end
    end
  end

  // Tx pacer: one byte out, then a guard cycle for a late tx_busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_READY;
      tx_data_r <= 8'h00;
      new_tx_r  <= 1'b0;
    end else if (fire_s) begin
      state_r   <= ST_GUARD;
      tx_data_r <= out_byte_s;
      new_tx_r  <= 1'b1;
    end else begin
      state_r   <= ST_READY;
      new_tx_r  <= 1'b0;
    end
  end

  assign bus.tx_data     = tx_data_r;
  assign bus.new_tx_data = new_tx_r;
  assign bus.channel     = channel_r;
  assign bus.mode        = mode_r;
  assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench for sample_streamer: directed scenarios plus a random
// phase, all compared cycle by cycle against a queue-based reference model.
module tb_sample_streamer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_streamer_if #(.SAMPLE_W(10), .CHAN_W(4)) bus ();

  sample_streamer #(.DEPTH(DEPTH), .SAMPLE_W(10), .CHAN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic [1:0] m_mode;
  logic [3:0] m_chan;
  bit         m_ovf, m_pend, m_guard, m_strobe;
  logic [7:0] m_pbyte, m_data;

  // observed tx log
  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] sent[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [7:0] rx  = bus.rx_data;
    bit         nrx = bus.new_rx_data;
    bit         ns  = bus.new_sample;
    logic [9:0] smp = bus.sample;
    logic [3:0] sch = bus.sample_channel;
    bit flush, ovf_set, is_data, hit, have_push, n_pend;
    logic [7:0] pv;
    if (!rst_n) begin
      m_q.delete();
      m_mode = 2'd0; m_chan = 4'hF; m_ovf = 1'b0; m_pend = 1'b0;
      m_guard = 1'b0; m_strobe = 1'b0; m_data = 8'h00; m_pbyte = 8'h00;
      return;
    end
    flush     = nrx && (rx == 8'hF0);
    is_data   = nrx && (rx < 8'hE0) && (m_mode == 2'd1);
    hit       = ns && (m_mode == 2'd2) && (sch == m_chan) && (m_chan != 4'hF);
    ovf_set   = 1'b0;
    have_push = 1'b0;
    n_pend    = 1'b0;
    pv        = 8'h00;
    if (m_pend) begin
      have_push = 1'b1;
      pv = m_pbyte;
      if (is_data || hit) ovf_set = 1'b1;
    end else if (is_data) begin
      if (m_q.size() < DEPTH) begin have_push = 1'b1; pv = rx; end
      else ovf_set = 1'b1;
    end else if (hit) begin
      if (DEPTH - m_q.size() >= 2) begin
        have_push = 1'b1;
        pv = {1'b1, sch, smp[9:7]};
        n_pend = 1'b1;
        m_pbyte = {1'b0, smp[6:0]};
      end else ovf_set = 1'b1;
    end
    if (flush) begin
      m_q.delete();
      have_push = 1'b0;
      n_pend = 1'b0;
    end
    if (have_push) m_q.push_back(pv);
    if (!m_guard && !bus.tx_busy && !flush && m_q.size() > 0) begin
      m_data = m_q.pop_front();
      m_strobe = 1'b1;
      m_guard = 1'b1;
    end else begin
      m_strobe = 1'b0;
      m_guard = 1'b0;
    end
    m_pend = n_pend;
    if (nrx && rx == 8'hF0) m_mode = 2'd0;
    if (nrx && rx == 8'hF1) m_mode = 2'd1;
    if (nrx && rx == 8'hF2) m_mode = 2'd2;
    if (nrx && rx[7:4] == 4'hE) m_chan = rx[3:0];
    if (ovf_set) m_ovf = 1'b1;
    else if (nrx && rx == 8'hF3) m_ovf = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("new_tx_data", bus.new_tx_data, m_strobe);
    chk("tx_data", bus.tx_data, m_data);
    chk("mode", bus.mode, m_mode);
    chk("channel", bus.channel, m_chan);
    chk("overflow", bus.overflow, m_ovf);
    if (bus.new_tx_data) begin
      got_q.push_back(bus.tx_data);
      got_t.push_back(cyc);
    end
    bus.new_rx_data = 1'b0;
    bus.new_sample  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data = b;
    bus.new_rx_data = 1'b1;
    step();
  endtask

  task automatic send_sample(input logic [3:0] ch, input logic [9:0] v);
    bus.sample_channel = ch;
    bus.sample = v;
    bus.new_sample = 1'b1;
    step();
  endtask

  int s_cyc;

  initial begin
    bus.rx_data = 8'h00; bus.new_rx_data = 1'b0; bus.new_sample = 1'b0;
    bus.sample = 10'h000; bus.sample_channel = 4'h0; bus.tx_busy = 1'b0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk("rst_channel", bus.channel, 32'hF);
    chk("rst_mode", bus.mode, 32'h0);
    chk("rst_overflow", bus.overflow, 32'h0);
    chk("rst_tx", {bus.new_tx_data, bus.tx_data}, 32'h0);

    // echo two bytes
    send_rx(8'hF1);
    got_q.delete(); got_t.delete();
    send_rx(8'h41);
    send_rx(8'h42);
    idle(4);
    chk("echo_cnt", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("echo_b0", got_q[0], 32'h41);
      chk("echo_b1", got_q[1], 32'h42);
      chk("echo_gap", got_t[1] - got_t[0], 32'd2);
    end
    chk("echo_mode", bus.mode, 32'd1);

    // stream frame and a non-matching sample
    send_rx(8'hE3);
    send_rx(8'hF2);
    got_q.delete(); got_t.delete();
    send_sample(4'd3, 10'h2A5);
    s_cyc = cyc;
    idle(4);
    send_sample(4'd2, 10'h155);
    idle(4);
    chk("frame_cnt", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("frame_b0", got_q[0], 32'h9D);
      chk("frame_b1", got_q[1], 32'h25);
      chk("frame_t0", got_t[0], s_cyc);
      chk("frame_t1", got_t[1], s_cyc + 2);
    end

    // fill beyond depth with tx held busy
    send_rx(8'hF1);
    bus.tx_busy = 1'b1;
    sent.delete(); got_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      sent.push_back(8'($urandom_range(0, 223)));
      send_rx(sent[i]);
    end
    chk("fill_ovf", bus.overflow, 32'd1);
    bus.tx_busy = 1'b0;
    idle(2 * DEPTH + 6);
    chk("fill_cnt", got_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) chk("fill_order", got_q[i], sent[i]);
    send_rx(8'hF3);
    chk("ovf_clr", bus.overflow, 32'd0);

    // frame refused with only one free entry
    bus.tx_busy = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) send_rx(8'($urandom_range(0, 223)));
    send_rx(8'hF2);
    send_sample(4'd3, 10'h3FF);
    chk("nofit_ovf", bus.overflow, 32'd1);
    send_rx(8'hF0);
    got_q.delete();
    bus.tx_busy = 1'b0;
    idle(6);
    chk("nofit_none", got_q.size(), 32'd0);

    // flush with five queued bytes
    send_rx(8'hF1);
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i));
    send_rx(8'hF0);
    bus.tx_busy = 1'b0;
    got_q.delete();
    idle(8);
    chk("flush_none", got_q.size(), 32'd0);
    chk("flush_mode", bus.mode, 32'd0);

    // reset while the second frame byte is pending
    send_rx(8'hE3);
    send_rx(8'hF2);
    got_q.delete();
    send_sample(4'd3, 10'h2A5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstp_channel", bus.channel, 32'hF);
    chk("rstp_mode", bus.mode, 32'd0);
    chk("rstp_ovf", bus.overflow, 32'd0);
    chk("rstp_tx", {bus.new_tx_data, bus.tx_data}, 32'h0);
    idle(5);
    chk("rstp_cnt", got_q.size(), 32'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int rr;
      bus.tx_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 30) begin
        rr = $urandom_range(0, 19);
        case (rr)
          0: bus.rx_data = 8'hF0;
          1: bus.rx_data = 8'hF1;
          2, 3: bus.rx_data = 8'hF2;
          4: bus.rx_data = 8'hF3;
          5: bus.rx_data = 8'hE0 + 8'($urandom_range(0, 4));
          6: bus.rx_data = 8'hF4 + 8'($urandom_range(0, 11));
          default: bus.rx_data = 8'($urandom_range(0, 223));
        endcase
        bus.new_rx_data = 1'b1;
      end
      if ($urandom_range(0, 99) < 40) begin
        bus.sample_channel = 4'($urandom_range(0, 4));
        bus.sample = 10'($urandom_range(0, 1023));
        bus.new_sample = 1'b1;
      end
      rst_n = ($urandom_range(0, 599) != 0);
      step();
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
